// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the EX-stage forwarding / hazard unit.
//   SEL_ID      : select value meaning "use the ID / register-file operand"
//   DEST_MAX_W  : storage width of a scoreboard destination field; register
//                 addresses narrower than this are zero-extended on entry
//   sb_entry_t  : one in-flight write record {dest, wb_en, mem_read}
//   sel_w()     : width of a per-operand forwarding select for a given depth
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int SEL_ID     = 0;
    localparam int DEST_MAX_W = 8;

    typedef struct packed {
        logic [DEST_MAX_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } sb_entry_t;

    // Selects encode 0 (ID value) plus one code per tracked stage.
    function automatic int sel_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// ----------------------------------------------------------------------------
// fwd_src_select
// Priority match of one EX operand against the in-flight write records.
//   fwd_en      in  : forwarding enabled
//   src         in  : operand register address
//   src_used    in  : operand is actually read
//   sb_dest     in  : destination per entry (entry 0 = MEM, youngest)
//   sb_wb_en    in  : write enable per entry
//   head_load   in  : entry 0 is a load whose data is not yet available
//   sel         out : 0 = ID value, k+1 = forward from entry k
// ----------------------------------------------------------------------------
module fwd_src_select
    import hazard_pkg::*;
#(
    parameter  int REG_W      = 4,
    parameter  int PIPE_DEPTH = 2,
    localparam int SEL_W      = sel_w(PIPE_DEPTH)
) (
    input  logic                                  fwd_en,
    input  logic [REG_W-1:0]                      src,
    input  logic                                  src_used,
    input  logic [PIPE_DEPTH-1:0][DEST_MAX_W-1:0] sb_dest,
    input  logic [PIPE_DEPTH-1:0]                 sb_wb_en,
    input  logic                                  head_load,
    output logic [SEL_W-1:0]                      sel
);

    always_comb begin
        sel = SEL_W'(SEL_ID);
        // Oldest first so the youngest matching entry overwrites.
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (fwd_en && src_used && sb_wb_en[k] &&
                sb_dest[k] == DEST_MAX_W'(src)) begin
                // A load still in MEM has no data yet; falling back to an
                // older match would forward a stale value, so select ID.
                if (k == 0 && head_load)
                    sel = SEL_W'(SEL_ID);
                else
                    sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_forward_scoreboard
// Tracks in-flight register writes from EX through MEM..WB, drives forwarding
// selects for the EX operands and raises the ID stall on hazards.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   fwd_en          : 1 = forwarding, 0 = stall-only mode
//   freeze          : whole-pipeline hold; scoreboard keeps its contents
//   ex_dest/ex_wb_en/ex_mem_read : write record of the EX instruction
//   ex_src/ex_src_used           : EX operand addresses / read flags
//   id_src/id_src_used           : ID operand addresses / read flags
//   sel_src         : per-operand select, 0 = ID value, k+1 = entry k
//   stall_id        : hold IF/ID and insert a bubble into EX
// Optional build macro FWD_PERF_CNT_EN adds saturating counters
//   fwd_cycles (cycles with any forwarding) and stall_cycles.
// ----------------------------------------------------------------------------
module hazard_forward_scoreboard
    import hazard_pkg::*;
#(
    parameter  int REG_W      = 4,
    parameter  int NUM_SRC    = 3,
    parameter  int PIPE_DEPTH = 2,
    localparam int SEL_W      = sel_w(PIPE_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fwd_en,
    input  logic                     freeze,
    input  logic [REG_W-1:0]         ex_dest,
    input  logic                     ex_wb_en,
    input  logic                     ex_mem_read,
    input  logic [NUM_SRC*REG_W-1:0] ex_src,
    input  logic [NUM_SRC-1:0]       ex_src_used,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]              fwd_cycles,
    output logic [31:0]              stall_cycles,
`endif
    output logic [NUM_SRC*SEL_W-1:0] sel_src,
    output logic                     stall_id
);

    sb_entry_t [PIPE_DEPTH-1:0]            sb_p1;
    logic [PIPE_DEPTH-1:0][DEST_MAX_W-1:0] sb_dest;
    logic [PIPE_DEPTH-1:0]                 sb_wb_en;
    logic                                  unused_tail_load;

    // Stage boundary: EX -> scoreboard (entry 0 = MEM ... entry D-1 = WB)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_p1 <= '0;
        end else if (!freeze) begin
            sb_p1[0] <= '{dest: DEST_MAX_W'(ex_dest), wb_en: ex_wb_en, mem_read: ex_mem_read};
            for (int k = 1; k < PIPE_DEPTH; k++)
                sb_p1[k] <= sb_p1[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            sb_dest[k]  = sb_p1[k].dest;
            sb_wb_en[k] = sb_p1[k].wb_en;
        end
    end

    // The oldest entry's load flag only matters while it sits in entry 0.
    assign unused_tail_load = sb_p1[PIPE_DEPTH-1].mem_read;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_select #(
            .REG_W      (REG_W),
            .PIPE_DEPTH (PIPE_DEPTH)
        ) u_sel (
            .fwd_en    (fwd_en),
            .src       (ex_src[i*REG_W +: REG_W]),
            .src_used  (ex_src_used[i]),
            .sb_dest   (sb_dest),
            .sb_wb_en  (sb_wb_en),
            .head_load (sb_p1[0].mem_read),
            .sel       (sel_src[i*SEL_W +: SEL_W])
        );
    end

    // With forwarding only a load in EX blocks its consumer; without it any
    // pending write to a source blocks until it has retired past WB.
    always_comb begin
        stall_id = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i]) begin
                if (ex_wb_en && ex_dest == id_src[i*REG_W +: REG_W] &&
                    (ex_mem_read || !fwd_en))
                    stall_id = 1'b1;
                if (!fwd_en) begin
                    for (int k = 0; k < PIPE_DEPTH; k++) begin
                        if (sb_p1[k].wb_en &&
                            sb_p1[k].dest == DEST_MAX_W'(id_src[i*REG_W +: REG_W]))
                            stall_id = 1'b1;
                    end
                end
            end
        end
        // The EX inputs are live during reset; keep the stall quiet then.
        if (!rst_n)
            stall_id = 1'b0;
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cycles   <= '0;
            stall_cycles <= '0;
        end else if (!freeze) begin
            if (|sel_src && fwd_cycles != 32'hFFFF_FFFF)
                fwd_cycles <= fwd_cycles + 32'd1;
            if (stall_id && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
module tb_hazard_forward_scoreboard;

    localparam int REG_W = 4;
    localparam int NUM_SRC = 3;
    localparam int PIPE_DEPTH = 2;
    localparam int SEL_W = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     fwd_en;
    logic                     freeze;
    logic [REG_W-1:0]         ex_dest;
    logic                     ex_wb_en;
    logic                     ex_mem_read;
    logic [NUM_SRC*REG_W-1:0] ex_src;
    logic [NUM_SRC-1:0]       ex_src_used;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_used;
    logic [NUM_SRC*SEL_W-1:0] sel_src;
    logic                     stall_id;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]              fwd_cycles;
    logic [31:0]              stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    hazard_forward_scoreboard #(
        .REG_W      (REG_W),
        .NUM_SRC    (NUM_SRC),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fwd_en       (fwd_en),
        .freeze       (freeze),
        .ex_dest      (ex_dest),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_read  (ex_mem_read),
        .ex_src       (ex_src),
        .ex_src_used  (ex_src_used),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
`ifdef FWD_PERF_CNT_EN
        .fwd_cycles   (fwd_cycles),
        .stall_cycles (stall_cycles),
`endif
        .sel_src      (sel_src),
        .stall_id     (stall_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] regs3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {c, b, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ed, input logic ew, input logic em,
                         input logic [11:0] es, input logic [2:0] eu,
                         input logic [11:0] is, input logic [2:0] iu);
        ex_dest = ed; ex_wb_en = ew; ex_mem_read = em;
        ex_src = es; ex_src_used = eu;
        id_src = is; id_src_used = iu;
        #1;
    endtask

    task automatic bubble();
        drive(4'd0, 1'b0, 1'b0, 12'h000, 3'b000, 12'h000, 3'b000);
    endtask

    task automatic flush();
        bubble();
        repeat (PIPE_DEPTH + 1) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fwd_en = 1'b1; freeze = 1'b0;
        drive(4'd3, 1'b1, 1'b1, regs3(4'd3, 4'd3, 4'd3), 3'b111, regs3(4'd3, 4'd0, 4'd0), 3'b001);
        checks++;
        if (sel_src !== 6'd0) begin errors++; $display("FAIL reset_sel got %0h want 0", sel_src); end
        checks++;
        if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_id); end
        repeat (2) step();
        checks++;
        if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall_clocked got %b want 0", stall_id); end
        rst_n = 1'b1;
        drive(4'd0, 1'b0, 1'b0, regs3(4'd3, 4'd0, 4'd0), 3'b001, 12'h000, 3'b000);
        checks++;
        if (sel_src !== 6'd0) begin errors++; $display("FAIL reset_entries_clear got %0h want 0", sel_src); end
        step();
    endtask

    task automatic test_forward();
        flush();
        drive(4'd3, 1'b1, 1'b0, regs3(4'd1, 4'd2, 4'd0), 3'b011, 12'h000, 3'b000);
        step();
        drive(4'd4, 1'b1, 1'b0, regs3(4'd3, 4'd1, 4'd0), 3'b011, 12'h000, 3'b000);
        checks++;
        if (sel_src !== 6'b00_00_01) begin errors++; $display("FAIL fwd_mem got %0h want 1", sel_src); end
        step();
        checks++;
        if (sel_src !== 6'b00_00_10) begin errors++; $display("FAIL fwd_wb got %0h want 2", sel_src); end
        fwd_en = 1'b0; #1;
        checks++;
        if (sel_src !== 6'd0) begin errors++; $display("FAIL fwd_off_sel got %0h want 0", sel_src); end
        fwd_en = 1'b1; #1;
        step();
        checks++;
        if (sel_src !== 6'd0) begin errors++; $display("FAIL fwd_retired got %0h want 0", sel_src); end
    endtask

    task automatic test_youngest();
        flush();
        drive(4'd3, 1'b1, 1'b0, 12'h000, 3'b000, 12'h000, 3'b000);
        step();
        step();
        drive(4'd0, 1'b0, 1'b0, regs3(4'd3, 4'd6, 4'd3), 3'b101, 12'h000, 3'b000);
        checks++;
        if (sel_src !== 6'b01_00_01) begin errors++; $display("FAIL youngest_wins got %0h want 11", sel_src); end
        drive(4'd0, 1'b0, 1'b0, regs3(4'd3, 4'd6, 4'd3), 3'b100, 12'h000, 3'b000);
        checks++;
        if (sel_src !== 6'b01_00_00) begin errors++; $display("FAIL unused_src got %0h want 10", sel_src); end
    endtask

    task automatic test_load_use();
        flush();
        drive(4'd5, 1'b1, 1'b1, 12'h000, 3'b000, regs3(4'd0, 4'd5, 4'd0), 3'b010);
        checks++;
        if (stall_id !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", stall_id); end
        step();
        drive(4'd0, 1'b0, 1'b0, 12'h000, 3'b000, regs3(4'd0, 4'd5, 4'd0), 3'b010);
        checks++;
        if (stall_id !== 1'b0) begin errors++; $display("FAIL load_use_one_bubble got %b want 0", stall_id); end
        step();
        drive(4'd8, 1'b1, 1'b0, regs3(4'd0, 4'd5, 4'd0), 3'b010, 12'h000, 3'b000);
        checks++;
        if (sel_src !== 6'b00_10_00) begin errors++; $display("FAIL load_use_fwd got %0h want 8", sel_src); end
        checks++;
        if (stall_id !== 1'b0) begin errors++; $display("FAIL load_use_no_stall got %b want 0", stall_id); end
    endtask

    task automatic test_load_skip();
        flush();
        drive(4'd5, 1'b1, 1'b0, 12'h000, 3'b000, 12'h000, 3'b000);
        step();
        drive(4'd5, 1'b1, 1'b1, 12'h000, 3'b000, 12'h000, 3'b000);
        step();
        drive(4'd0, 1'b0, 1'b0, regs3(4'd0, 4'd5, 4'd0), 3'b010, 12'h000, 3'b000);
        checks++;
        if (sel_src !== 6'd0) begin errors++; $display("FAIL load_head_skip got %0h want 0", sel_src); end
    endtask

    task automatic test_stall_only();
        int n;
        flush();
        fwd_en = 1'b0;
        n = 0;
        drive(4'd2, 1'b1, 1'b0, 12'h000, 3'b000, regs3(4'd2, 4'd0, 4'd0), 3'b001);
        for (int c = 0; c < 5; c++) begin
            if (stall_id === 1'b1) n++;
            checks++;
            if (sel_src !== 6'd0) begin errors++; $display("FAIL stall_only_sel cycle %0d got %0h want 0", c, sel_src); end
            step();
            drive(4'd0, 1'b0, 1'b0, regs3(4'd2, 4'd0, 4'd0), 3'b001, regs3(4'd2, 4'd0, 4'd0), 3'b001);
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL stall_only_len got %0d want 3", n); end
        fwd_en = 1'b1;
    endtask

    task automatic test_freeze();
        flush();
        drive(4'd7, 1'b1, 1'b0, 12'h000, 3'b000, 12'h000, 3'b000);
        step();
        freeze = 1'b1;
        drive(4'd9, 1'b1, 1'b1, regs3(4'd7, 4'd0, 4'd0), 3'b001, regs3(4'd0, 4'd0, 4'd9), 3'b100);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (sel_src !== 6'b00_00_01) begin errors++; $display("FAIL freeze_hold cycle %0d got %0h want 1", c, sel_src); end
            checks++;
            if (stall_id !== 1'b1) begin errors++; $display("FAIL freeze_stall cycle %0d got %b want 1", c, stall_id); end
            step();
        end
        freeze = 1'b0;
        drive(4'd0, 1'b0, 1'b0, regs3(4'd7, 4'd0, 4'd0), 3'b001, 12'h000, 3'b000);
        step();
        checks++;
        if (sel_src !== 6'b00_00_10) begin errors++; $display("FAIL unfreeze_shift got %0h want 2", sel_src); end
        drive(4'd9, 1'b1, 1'b1, regs3(4'd7, 4'd0, 4'd0), 3'b001, regs3(4'd9, 4'd0, 4'd0), 3'b001);
        rst_n = 1'b0; #1;
        checks++;
        if (sel_src !== 6'd0) begin errors++; $display("FAIL async_reset_sel got %0h want 0", sel_src); end
        checks++;
        if (stall_id !== 1'b0) begin errors++; $display("FAIL async_reset_stall got %b want 0", stall_id); end
        rst_n = 1'b1;
        step();
        checks++;
        if (sel_src !== 6'd0) begin errors++; $display("FAIL reset_discard got %0h want 0", sel_src); end
    endtask

`ifdef FWD_PERF_CNT_EN
    task automatic test_perf();
        bubble();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        drive(4'd3, 1'b1, 1'b0, 12'h000, 3'b000, 12'h000, 3'b000);
        step();
        drive(4'd3, 1'b1, 1'b0, regs3(4'd3, 4'd0, 4'd0), 3'b001, 12'h000, 3'b000);
        repeat (10) step();
        drive(4'd5, 1'b1, 1'b1, 12'h000, 3'b000, regs3(4'd0, 4'd5, 4'd0), 3'b010);
        repeat (2) step();
        bubble();
        step();
        checks++;
        if (fwd_cycles !== 32'd10) begin errors++; $display("FAIL perf_fwd got %0d want 10", fwd_cycles); end
        checks++;
        if (stall_cycles !== 32'd2) begin errors++; $display("FAIL perf_stall got %0d want 2", stall_cycles); end
        dut.fwd_cycles = 32'hFFFF_FFFE;
        drive(4'd3, 1'b1, 1'b0, 12'h000, 3'b000, 12'h000, 3'b000);
        step();
        drive(4'd3, 1'b1, 1'b0, regs3(4'd3, 4'd0, 4'd0), 3'b001, 12'h000, 3'b000);
        repeat (3) step();
        checks++;
        if (fwd_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_saturate got %0h want ffffffff", fwd_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_youngest();
        test_load_use();
        test_load_skip();
        test_stall_only();
        test_freeze();
`ifdef FWD_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
